dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Sequencer between the MEM pipeline stage and a single-port, word-wide, handshaked data memory. Decodes word/half/byte loads and stores, generates byte enables and replicated store data, and holds the pipeline with `stall` until the memory acknowledges. Sign- or zero-extends load data into a registered result. Flags misaligned accesses and memory timeouts.

## Interface
- `ADDR_W`, default 12: word-address width driven to memory; byte address bits used are `[ADDR_W+1:0]`.
- `TIMEOUT`, default 16: maximum BUSY cycles without `mem_ack` before bus error; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_en` in 1: MEM stage holds a valid load/store.
- `is_store` in 1: 1 = store, 0 = load.
- `word_bit` in 2: access size; 0 = word, 1 = half, 2 = byte, 3 = reserved.
- `load_u` in 1: 1 = zero-extend load, 0 = sign-extend.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data from rt.
- `stall` out 1: hold the pipeline; combinational.
- `align_err` out 1: misaligned or reserved access; combinational.
- `done` out 1: access finished this cycle; registered.
- `bus_err` out 1: access ended by timeout; registered.
- `rdata` out 32: extended load result, valid while `done`=1; registered.
- `mem_req` out 1: memory request; registered.
- `mem_we` out 1: write strobe; registered.
- `mem_addr` out ADDR_W: word address; registered.
- `mem_be` out 4: byte enables, bit i selects `[8i+7:8i]`; registered.
- `mem_wdata` out 32: memory write data; registered.
- `mem_rdata` in 32: memory read word, valid with `mem_ack`.
- `mem_ack` in 1: memory completion, one cycle while `mem_req`=1.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Alignment check:**
  - `aligned` = (word_bit==0 && addr[1:0]==0) || (word_bit==1 && addr[0]==0) || word_bit==2.
  - word_bit==3 is never aligned.
- **IDLE:**
  - If `mem_en` and not `aligned`: `align_err`=1, no request, `stall`=0, stay in IDLE.
  - If `mem_en` and `aligned`: register request fields, set `mem_req`=1, clear the timeout counter, go to BUSY.
- **Request fields:**
  - `mem_addr` = addr[ADDR_W+1:2]; `mem_we` = is_store.
  - Word: `be`=1111, `wdata`=wdata.
  - Half: `be`=0011 if addr[1]==0 else 1100; `wdata`={2{wdata[15:0]}}.
  - Byte: `be`=0001<<addr[1:0]; `wdata`={4{wdata[7:0]}}.
  - Loads drive the same `be`. The memory ignores it on reads.
- **BUSY:**
  - All `mem_*` outputs stay stable.
  - The counter increments each cycle `mem_ack`=0.
  - On `mem_ack`=1: drop `mem_req`. For a load, capture the extended `mem_rdata` into `rdata`. For a store, `rdata`=0. Go to DONE with `done`=1.
  - When the counter reaches TIMEOUT-1 without ack: drop `mem_req`, `rdata`=0, `bus_err`=1, `done`=1, go to DONE.
- **DONE:**
  - `stall`=0, so the pipeline advances at the end of this cycle.
  - `done` and `bus_err` clear on the next edge. Next state is IDLE.
- **Load extension:**
  - Half: source is mem_rdata[15:0] if addr[1]==0, else [31:16].
  - Byte: source is byte addr[1:0] of mem_rdata.
  - `load_u`=1 zero-fills the upper bits; otherwise the sign bit of the selected field is replicated.
- **Stall:** `stall` = (IDLE && mem_en && aligned) || BUSY.
- **Acknowledge outside BUSY:** `mem_ack` is ignored.
- **Input stability:** Inputs are assumed stable while `stall`=1. They are only sampled in IDLE.

## Timing
- **Reset:** state IDLE, counter 0. `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `rdata`, `done`, `bus_err` all 0. Combinational outputs follow IDLE rules.
- **Minimum access (ack in first BUSY cycle):**
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: BUSY, `stall`=1, ack.
  - Cycle 2: DONE, `stall`=0, `done`=1.
  - Total: 2 stall cycles.
- **Each extra ack wait** adds one stall cycle.
- **Timeout:** the access ends with `bus_err` in DONE exactly TIMEOUT+1 cycles after cycle 0.
- **Back-to-back:** a new access is accepted in the IDLE cycle immediately after DONE. There is no combinational path from `mem_ack` to `mem_req`.
- **Reset mid-BUSY:** `mem_req` drops on the reset edge and the pending access is discarded. A late `mem_ack` is ignored.

## Test plan
- **lw:** addr=0x0000_0104, ack on first BUSY cycle, mem_rdata=0xDEAD_BEEF.
  - mem_addr=0x041, be=1111, we=0.
  - Exactly 2 stall cycles; done with rdata=0xDEAD_BEEF.
- **lb / lbu:** addr=0x0000_0003, mem_rdata=0x80FF_0011.
  - lb → rdata=0xFFFF_FF80.
  - lbu → rdata=0x0000_0080.
- **lh / lhu:** addr=0x0000_0002, mem_rdata=0x8001_7FFF.
  - lh → 0xFFFF_8001.
  - lhu → 0x0000_8001.
- **sb / sh:**
  - sb at addr 0x0000_0006, wdata=0x1234_56AB → be=0100, mem_wdata=0xABAB_ABAB, we=1.
  - sh at addr 0x0000_0002, same wdata → be=1100, mem_wdata=0x56AB_56AB, we=1.
- **Misaligned:** lw at 0x0000_0002, or lh at 0x0000_0001.
  - align_err=1, stall=0, mem_req stays 0.
- **Timeout and reset:**
  - mem_ack held 0 with TIMEOUT=16 → bus_err=1 and done=1 at cycle 17, rdata=0.
  - Separately, assert reset in BUSY → mem_req=0 next cycle, state IDLE, later ack ignored.

Source files
------------

// File: rtl/dm_mem_if.sv
// dm_mem_if: handshaked single-port word-wide data memory bus
interface dm_mem_if #(parameter int ADDR_W = 12);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;
   modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
   modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage load/store sequencer for a handshaked data memory
module dm_access_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_en,
   input  logic        is_store,
   input  logic [1:0]  word_bit,
   input  logic        load_u,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        align_err,
   output logic        done,
   output logic        bus_err,
   output logic [31:0] rdata,
   dm_mem_if.master    mem
);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    sz, off;
   logic          lu;
   logic          aligned, start, tmo, unused_addr;
   logic [3:0]    be;
   logic [31:0]   wd, ext;
   logic [15:0]   h;
   logic [7:0]    b;
   always_comb begin
      aligned     = (word_bit == 2'd0 && addr[1:0] == 2'd0) || (word_bit == 2'd1 && !addr[0]) || word_bit == 2'd2;
      start       = state == IDLE && mem_en && aligned;
      align_err   = state == IDLE && mem_en && !aligned;
      stall       = start || state == BUSY;
      tmo         = cnt == CW'(TIMEOUT - 1);
      be          = word_bit == 2'd0 ? 4'hf : word_bit == 2'd1 ? (addr[1] ? 4'hc : 4'h3) : 4'h1 << addr[1:0];
      wd          = word_bit == 2'd0 ? wdata : word_bit == 2'd1 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
      h           = off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      b           = mem.mem_rdata[{off, 3'b000} +: 8];
      ext         = sz == 2'd0 ? mem.mem_rdata : sz == 2'd1 ? {{16{h[15] & ~lu}}, h} : {{24{b[7] & ~lu}}, b};
      unused_addr = ^addr[31:ADDR_W+2];
   end
   // size/offset/sign are latched at accept so extension never depends on live inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         sz            <= '0;
         off           <= '0;
         lu            <= 1'b0;
         done          <= 1'b0;
         bus_err       <= 1'b0;
         rdata         <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
      end else begin
         done    <= 1'b0;
         bus_err <= 1'b0;
         if (start) begin
            state         <= BUSY;
            cnt           <= '0;
            sz            <= word_bit;
            off           <= addr[1:0];
            lu            <= load_u;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= addr[ADDR_W+1:2];
            mem.mem_be    <= be;
            mem.mem_wdata <= wd;
         end else if (state == BUSY) begin
            if (mem.mem_ack || tmo) begin
               state       <= DONE;
               mem.mem_req <= 1'b0;
               done        <= 1'b1;
               bus_err     <= !mem.mem_ack;
               rdata       <= mem.mem_ack && !mem.mem_we ? ext : '0;
            end else cnt <= cnt + CW'(1);
         end else if (state == DONE) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed table, timeout/reset sequences and randomized model checks
module tb_dm_access_ctrl;
   localparam int TIMEOUT = 16;
   logic clk = 0, reset = 1, mem_en = 0, is_store = 0, load_u = 0;
   logic [1:0] word_bit = 0;
   logic [31:0] addr = 0, wdata = 0, rdata;
   logic stall, align_err, done, bus_err;
   int tests = 0, fails = 0;
   dm_mem_if #(.ADDR_W(12)) bus ();
   dm_access_ctrl #(.ADDR_W(12), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .mem_en(mem_en), .is_store(is_store), .word_bit(word_bit),
      .load_u(load_u), .addr(addr), .wdata(wdata), .stall(stall), .align_err(align_err),
      .done(done), .bus_err(bus_err), .rdata(rdata), .mem(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic st; logic [1:0] wb; logic lu; logic [31:0] a, wd, mrd;
      logic err; logic [3:0] be; logic [31:0] mwd, rd;
   } vec_t;
   vec_t tbl[11];
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   // reference built from byte arithmetic: size in bytes, shifts and masks
   function automatic void model(input logic st, input logic [1:0] wb, input logic lu,
                                 input logic [31:0] a, wd, mrd,
                                 output logic err, output logic [3:0] be, output logic [31:0] mwd, rd);
      int n;
      logic [31:0] mask, v;
      n    = wb == 0 ? 4 : wb == 1 ? 2 : 1;
      err  = wb == 3 || (a % n) != 0;
      be   = 4'(((1 << n) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wd[8*(i % n) +: 8];
      mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
      v    = (mrd >> (8 * (a % 4))) & mask;
      if (!lu && n < 4 && v[8*n-1]) v = v | ~mask;
      rd   = st ? 32'd0 : v;
   endfunction
   task automatic run(input logic st, input logic [1:0] wb, input logic lu, input logic [31:0] a, wd, mrd,
                      input int dly, input logic e_err, input logic [3:0] e_be, input logic [31:0] e_wd, e_rd);
      int c, w;
      logic fin, first, e_bus;
      e_bus = dly >= TIMEOUT;
      @(negedge clk);
      mem_en = 1; is_store = st; word_bit = wb; load_u = lu; addr = a; wdata = wd;
      #1;
      chk("align_err", 32'(align_err), 32'(e_err));
      if (e_err) begin
         chk("stall_misaligned", 32'(stall), 0);
         @(posedge clk); #1;
         chk("req_misaligned", 32'(bus.mem_req), 0);
         mem_en = 0;
         return;
      end
      c = 0; w = 0; fin = 0; first = 1;
      while (!fin && c < 64) begin
         if (stall) c++;
         if (bus.mem_req) begin
            if (first) begin
               chk("mem_we", 32'(bus.mem_we), 32'(st));
               chk("mem_addr", 32'(bus.mem_addr), (a >> 2) % 4096);
               chk("mem_be", 32'(bus.mem_be), 32'(e_be));
               chk("mem_wdata", bus.mem_wdata, e_wd);
               first = 0;
            end
            bus.mem_rdata = mrd;
            bus.mem_ack = (w == dly);
            w++;
         end
         @(posedge clk); #1;
         bus.mem_ack = 0;
         if (done) begin
            fin = 1;
            chk("stall_in_done", 32'(stall), 0);
            chk("bus_err", 32'(bus_err), 32'(e_bus));
            chk("rdata", rdata, e_bus ? 32'd0 : e_rd);
            chk("req_in_done", 32'(bus.mem_req), 0);
         end else begin
            @(negedge clk); #1;
         end
      end
      if (!fin) chk("done_never_seen", 0, 1);
      chk("stall_cycles", c, e_bus ? TIMEOUT + 1 : dly + 2);
      mem_en = 0;
      @(posedge clk); #1;
      chk("done_clear", {30'd0, done, bus_err}, 0);
   endtask
   initial begin
      logic e; logic [3:0] be; logic [31:0] mwd, rd, a, wd, mrd;
      logic st, lu; logic [1:0] wb; int dly;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      tbl[0]  = '{0, 2'd0, 0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 4'hF, 32'h0, 32'hDEAD_BEEF};
      tbl[1]  = '{0, 2'd2, 0, 32'h0000_0003, 32'h0, 32'h80FF_0011, 0, 4'h8, 32'h0, 32'hFFFF_FF80};
      tbl[2]  = '{0, 2'd2, 1, 32'h0000_0003, 32'h0, 32'h80FF_0011, 0, 4'h8, 32'h0, 32'h0000_0080};
      tbl[3]  = '{0, 2'd1, 0, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 4'hC, 32'h0, 32'hFFFF_8001};
      tbl[4]  = '{0, 2'd1, 1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 4'hC, 32'h0, 32'h0000_8001};
      tbl[5]  = '{1, 2'd2, 0, 32'h0000_0006, 32'h1234_56AB, 32'h0, 0, 4'h4, 32'hABAB_ABAB, 32'h0};
      tbl[6]  = '{1, 2'd1, 0, 32'h0000_0002, 32'h1234_56AB, 32'h0, 0, 4'hC, 32'h56AB_56AB, 32'h0};
      tbl[7]  = '{0, 2'd0, 0, 32'h0000_0002, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0};
      tbl[8]  = '{0, 2'd1, 0, 32'h0000_0001, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0};
      tbl[9]  = '{0, 2'd3, 0, 32'h0000_0000, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0};
      tbl[10] = '{1, 2'd0, 0, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0, 0, 4'hF, 32'hCAFE_F00D, 32'h0};
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 0; #1;
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_be", 32'(bus.mem_be), 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_done_buserr", {30'd0, done, bus_err}, 0);
      chk("rst_stall", 32'(stall), 0);
      for (int i = 0; i < 11; i++)
         run(tbl[i].st, tbl[i].wb, tbl[i].lu, tbl[i].a, tbl[i].wd, tbl[i].mrd, i % 3,
             tbl[i].err, tbl[i].be, tbl[i].mwd, tbl[i].rd);
      // memory never answers: timeout path
      run(0, 2'd0, 0, 32'h0000_0010, 32'h0, 32'h1111_2222, 100, 0, 4'hF, 32'h0, 32'h0);
      // reset while BUSY discards the access and a late ack is ignored
      @(negedge clk);
      mem_en = 1; is_store = 0; word_bit = 0; addr = 32'h20;
      @(negedge clk);
      chk("busy_req", 32'(bus.mem_req), 1);
      reset = 1; mem_en = 0;
      @(posedge clk); #1;
      reset = 0;
      chk("reset_busy_req", 32'(bus.mem_req), 0);
      chk("reset_busy_stall", 32'(stall), 0);
      @(negedge clk);
      bus.mem_ack = 1; bus.mem_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      bus.mem_ack = 0;
      chk("late_ack_done", 32'(done), 0);
      chk("late_ack_rdata", rdata, 0);
      chk("late_ack_req", 32'(bus.mem_req), 0);
      for (int i = 0; i < 40; i++) begin
         st = 1'($urandom); wb = 2'($urandom); lu = 1'($urandom);
         a = $urandom; wd = $urandom; mrd = $urandom;
         dly = ($urandom % 10 == 0) ? 30 : int'($urandom % 4);
         model(st, wb, lu, a, wd, mrd, e, be, mwd, rd);
         run(st, wb, lu, a, wd, mrd, dly, e, be, mwd, rd);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
